ysyx_24100006_prefetch_ifu: RTL and testbench

YSYX_24100006_PREFETCH_IFU -- requirements
Module: ysyx_24100006_prefetch_ifu

---
 rtl/ysyx_24100006_ifu_pkg.sv | 22 ++
 rtl/ysyx_24100006_sync_fifo.sv | 65 ++++++
 rtl/ysyx_24100006_prefetch_ifu.sv | 143 ++++++++++++++
 tb/tb_ysyx_24100006_prefetch_ifu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package ysyx_24100006_ifu_pkg;

  localparam int EPOCH_W = 2;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ifu_entry_t;

  typedef struct packed {
    logic [EPOCH_W-1:0] epoch;
    logic [31:0]        pc;
  } req_tag_t;

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ysyx_24100006_sync_fifo.sv
// Synchronous FIFO with registered storage; push and pop may coincide when full.
module ysyx_24100006_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [4:0]       count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full    = (count_q == 5'(DEPTH));
    do_pop  = pop && (count_q != 5'd0);
    do_push = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + 5'(do_push) - 5'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 5'd0);
  assign count = count_q;

endmodule

// File: rtl/ysyx_24100006_prefetch_ifu.sv
// Prefetching IFU: AXI read issue, epoch-tagged in-order returns, instruction buffer.
// Optional static JAL prediction under YSYX_24100006_IFU_JAL_PREDICT_EN.
module ysyx_24100006_prefetch_ifu
  import ysyx_24100006_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h3000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  output logic        if_out_valid,
  input  logic        if_out_ready,
  output logic [31:0] if_out_inst,
  output logic [31:0] if_out_pc,
  output logic        if_out_fault
);

  localparam int         TW      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);
  localparam logic [4:0] MAX_C   = 5'(MAX_OUTSTANDING);

  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               arvalid_q, arvalid_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [4:0]         issue_cnt_q, issue_cnt_d;
  logic               stop_q, stop_d;
  req_tag_t           tagq_q [MAX_OUTSTANDING];
  req_tag_t           tagq_d [MAX_OUTSTANDING];
  logic [TW-1:0]      tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic        redir, kill, ar_hs, r_hs, beat_ok, pop, jal_hit, can_issue;
  logic [31:0] redir_pc;
  logic [4:0]  fifo_cnt, fifo_cnt_d;
  logic        fifo_empty;
  req_tag_t    head;
  ifu_entry_t  push_entry, fifo_dout;
`ifdef YSYX_24100006_IFU_JAL_PREDICT_EN
  logic [31:0] jal_tgt;
`endif

  always_comb begin
    redir  = redirect_valid || flush;
    ar_hs  = arvalid_q && axi_arready;
    r_hs   = axi_rvalid && (issue_cnt_q != 5'd0);
    head   = tagq_q[tag_rd_q];
    // Beats from an older epoch, or landing on a redirect cycle, are discarded.
    beat_ok          = r_hs && (head.epoch == epoch_q) && !redir;
    push_entry.inst  = axi_rdata;
    push_entry.pc    = head.pc;
    push_entry.fault = (axi_rresp != 2'b00);
    pop    = !fifo_empty && if_out_ready;
`ifdef YSYX_24100006_IFU_JAL_PREDICT_EN
    jal_hit = beat_ok && (axi_rdata[6:0] == OPC_JAL);
    jal_tgt = head.pc + j_imm(axi_rdata);
`else
    jal_hit = 1'b0;
`endif
    redir_pc = redirect_valid ? redirect_pc : (fifo_empty ? fetch_pc_q : fifo_dout.pc);
    kill     = redir || jal_hit;

    fetch_pc_d = fetch_pc_q;
    if (ar_hs) fetch_pc_d = fetch_pc_q + 32'd4;
`ifdef YSYX_24100006_IFU_JAL_PREDICT_EN
    if (jal_hit) fetch_pc_d = jal_tgt;
`endif
    if (redir) fetch_pc_d = redir_pc;
    epoch_d = epoch_q + EPOCH_W'(kill);

    tagq_d   = tagq_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (ar_hs) begin
      tagq_d[tag_wr_q] = '{epoch: epoch_q, pc: fetch_pc_q};
      tag_wr_d = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
    end
    if (r_hs) tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;

    issue_cnt_d = issue_cnt_q + 5'(ar_hs) - 5'(r_hs);
    stop_d      = redir ? 1'b0 : (stop_q || (beat_ok && push_entry.fault));
    fifo_cnt_d  = redir ? 5'd0 : (fifo_cnt + 5'(beat_ok) - 5'(pop));

    // Look ahead with next-cycle state so every accepted beat has a free slot.
    can_issue = (issue_cnt_d < MAX_C) && ((DEPTH_C - fifo_cnt_d) > issue_cnt_d) && !stop_d;
    arvalid_d = (arvalid_q && !ar_hs && !kill) || can_issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      arvalid_q   <= 1'b0;
      epoch_q     <= '0;
      issue_cnt_q <= '0;
      stop_q      <= 1'b0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tagq_q[i] <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      arvalid_q   <= arvalid_d;
      epoch_q     <= epoch_d;
      issue_cnt_q <= issue_cnt_d;
      stop_q      <= stop_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      tagq_q      <= tagq_d;
    end
  end

  ysyx_24100006_sync_fifo #(
    .WIDTH($bits(ifu_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .clear(redir),
    .push (beat_ok),
    .din  (push_entry),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  assign axi_araddr   = fetch_pc_q;
  assign axi_arvalid  = arvalid_q;
  assign axi_rready   = (issue_cnt_q != 5'd0);
  assign if_out_valid = !fifo_empty;
  assign if_out_inst  = fifo_dout.inst;
  assign if_out_pc    = fifo_dout.pc;
  assign if_out_fault = fifo_dout.fault;

endmodule

// File: tb/tb_ysyx_24100006_prefetch_ifu.sv
// Directed bench for the prefetch IFU with a zero-wait in-order AXI read responder.
module tb_ysyx_24100006_prefetch_ifu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready = 1'b1;
  logic [31:0] axi_rdata = 32'h0;
  logic [1:0]  axi_rresp = 2'b00;
  logic        axi_rvalid = 1'b0;
  logic        axi_rready;
  logic        if_out_valid;
  logic        if_out_ready = 1'b0;
  logic [31:0] if_out_inst;
  logic [31:0] if_out_pc;
  logic        if_out_fault;

  int n_checks = 0;
  int n_fail = 0;

  logic        resp_en = 1'b1;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  logic [31:0] jal_addr = 32'hFFFF_FFFF;
  logic [31:0] mq[$];
  int          hs_total = 0;

  logic [31:0] pops_pc[$];
  logic [31:0] pops_inst[$];
  logic        pops_f[$];
  int          pops_cyc[$];

  ysyx_24100006_prefetch_ifu dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .if_out_valid(if_out_valid), .if_out_ready(if_out_ready),
    .if_out_inst(if_out_inst), .if_out_pc(if_out_pc), .if_out_fault(if_out_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == jal_addr) ? 32'h0100_006F : {a[23:0], 8'h13};
  endfunction

  // Memory: accept AR at an edge, present R one edge later, strictly in order.
  always @(posedge clk) begin
    logic        hs, take;
    logic [31:0] a;
    hs   = axi_arvalid && axi_arready;
    take = axi_rvalid && axi_rready;
    a    = axi_araddr;
    if (reset) mq.delete();
    else begin
      if (take && mq.size() > 0) void'(mq.pop_front());
      if (hs) begin
        mq.push_back(a);
        hs_total++;
      end
    end
    #1;
    if (resp_en && mq.size() > 0) begin
      axi_rvalid = 1'b1;
      axi_rdata  = mem_word(mq[0]);
      axi_rresp  = (mq[0] == fault_addr) ? 2'b10 : 2'b00;
    end else begin
      axi_rvalid = 1'b0;
      axi_rdata  = 32'h0;
      axi_rresp  = 2'b00;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    flush = 1'b0;
    axi_arready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic collect(input int want, input int max_cyc);
    pops_pc.delete(); pops_inst.delete(); pops_f.delete(); pops_cyc.delete();
    for (int c = 0; c < max_cyc && pops_pc.size() < want; c++) begin
      if (if_out_valid && if_out_ready) begin
        pops_pc.push_back(if_out_pc);
        pops_inst.push_back(if_out_inst);
        pops_f.push_back(if_out_fault);
        pops_cyc.push_back(c);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", axi_arvalid); end
    n_checks++; if (axi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready: got %b expected 0", axi_rready); end
    n_checks++; if (if_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_out_valid); end
    n_checks++; if ({if_out_inst, if_out_pc, if_out_fault} !== 65'h0) begin n_fail++; $display("FAIL reset_outputs: got %h/%h/%b expected 0", if_out_inst, if_out_pc, if_out_fault); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h3000_0000) begin n_fail++; $display("FAIL first_ar: got %b/%h expected 1/30000000", axi_arvalid, axi_araddr); end
  endtask

  task automatic test_latency();
    int t_ar, t_v;
    if_out_ready = 1'b1;
    do_reset();
    t_ar = -1; t_v = -1;
    for (int c = 0; c < 20 && t_v < 0; c++) begin
      if (t_ar < 0 && axi_arvalid && axi_arready) t_ar = c;
      if (if_out_valid) t_v = c;
      @(negedge clk);
    end
    n_checks++; if (t_v - t_ar !== 2) begin n_fail++; $display("FAIL latency: got %0d expected 2 (ar %0d valid %0d)", t_v - t_ar, t_ar, t_v); end
  endtask

  task automatic test_sequential();
    if_out_ready = 1'b1;
    do_reset();
    collect(4, 30);
    n_checks++; if (pops_pc.size() != 4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", pops_pc.size()); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (pops_pc[k] !== 32'h3000_0000 + 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc%0d: got %h expected %h", k, pops_pc[k], 32'h3000_0000 + 32'(4 * k)); end
    end
    n_checks++; if (pops_inst[1] !== 32'h0000_0413) begin n_fail++; $display("FAIL seq_inst: got %h expected 00000413", pops_inst[1]); end
    n_checks++; if (pops_cyc[1] != pops_cyc[0] + 1 || pops_cyc[2] != pops_cyc[1] + 1) begin n_fail++; $display("FAIL seq_back_to_back: got cycles %0d %0d %0d expected consecutive", pops_cyc[0], pops_cyc[1], pops_cyc[2]); end
  endtask

  task automatic test_backpressure();
    int h0;
    if_out_ready = 1'b0;
    do_reset();
    h0 = hs_total;
    repeat (20) @(negedge clk);
    n_checks++; if (hs_total - h0 != 4) begin n_fail++; $display("FAIL bp_ar_count: got %0d expected 4", hs_total - h0); end
    n_checks++; if (axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_arvalid: got %b expected 0", axi_arvalid); end
    n_checks++; if (if_out_valid !== 1'b1 || if_out_pc !== 32'h3000_0000) begin n_fail++; $display("FAIL bp_head: got %b/%h expected 1/30000000", if_out_valid, if_out_pc); end
    if_out_ready = 1'b1;
    collect(8, 40);
    n_checks++; if (pops_pc.size() != 8) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected 8", pops_pc.size()); end
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (pops_pc[k] !== 32'h3000_0000 + 32'(4 * k)) begin n_fail++; $display("FAIL bp_drain_pc%0d: got %h expected %h", k, pops_pc[k], 32'h3000_0000 + 32'(4 * k)); end
    end
  endtask

  task automatic test_redirect();
    int h0;
    if_out_ready = 1'b1;
    resp_en = 1'b0;
    do_reset();
    h0 = hs_total;
    repeat (6) @(negedge clk);
    n_checks++; if (hs_total - h0 != 2 || axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL redir_inflight: got %0d/%b expected 2/0", hs_total - h0, axi_arvalid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0000;
    @(negedge clk);
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    collect(2, 30);
    n_checks++; if (pops_pc[0] !== 32'h8000_0000) begin n_fail++; $display("FAIL redir_pc0: got %h expected 80000000", pops_pc[0]); end
    n_checks++; if (pops_pc[1] !== 32'h8000_0004) begin n_fail++; $display("FAIL redir_pc1: got %h expected 80000004", pops_pc[1]); end
  endtask

  task automatic test_flush();
    if_out_ready = 1'b0;
    do_reset();
    repeat (12) @(negedge clk);
    if_out_ready = 1'b1;
    @(negedge clk);
    if_out_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (if_out_pc !== 32'h3000_0004) begin n_fail++; $display("FAIL flush_head: got %h expected 30000004", if_out_pc); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    if_out_ready = 1'b1;
    collect(2, 30);
    n_checks++; if (pops_pc[0] !== 32'h3000_0004 || pops_pc[1] !== 32'h3000_0008) begin n_fail++; $display("FAIL flush_refetch: got %h %h expected 30000004 30000008", pops_pc[0], pops_pc[1]); end
  endtask

  task automatic test_priority();
    if_out_ready = 1'b1;
    do_reset();
    repeat (6) @(negedge clk);
    redirect_valid = 1'b1;
    flush = 1'b1;
    redirect_pc = 32'h8000_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    flush = 1'b0;
    collect(1, 30);
    n_checks++; if (pops_pc[0] !== 32'h8000_0040) begin n_fail++; $display("FAIL priority_pc: got %h expected 80000040", pops_pc[0]); end
  endtask

  task automatic test_fault();
    int h1;
    if_out_ready = 1'b1;
    fault_addr = 32'h3000_0008;
    do_reset();
    collect(3, 30);
    n_checks++; if (pops_pc[2] !== 32'h3000_0008 || pops_f[2] !== 1'b1) begin n_fail++; $display("FAIL fault_entry: got %h/%b expected 30000008/1", pops_pc[2], pops_f[2]); end
    n_checks++; if (pops_f[0] !== 1'b0) begin n_fail++; $display("FAIL fault_clean: got %b expected 0", pops_f[0]); end
    h1 = hs_total;
    repeat (10) @(negedge clk);
    n_checks++; if (hs_total != h1 || axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL fault_stop: got %0d new ARs, arvalid %b expected 0/0", hs_total - h1, axi_arvalid); end
    fault_addr = 32'hFFFF_FFFF;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    collect(1, 30);
    n_checks++; if (pops_pc[0] !== 32'h3000_0100 || pops_f[0] !== 1'b0) begin n_fail++; $display("FAIL fault_resume: got %h/%b expected 30000100/0", pops_pc[0], pops_f[0]); end
  endtask

  task automatic test_jal();
    logic [31:0] exp1;
`ifdef YSYX_24100006_IFU_JAL_PREDICT_EN
    exp1 = 32'h3000_0010;
`else
    exp1 = 32'h3000_0004;
`endif
    if_out_ready = 1'b1;
    jal_addr = 32'h3000_0000;
    do_reset();
    collect(3, 30);
    jal_addr = 32'hFFFF_FFFF;
    n_checks++; if (pops_pc[0] !== 32'h3000_0000 || pops_inst[0] !== 32'h0100_006F) begin n_fail++; $display("FAIL jal_first: got %h/%h expected 30000000/0100006f", pops_pc[0], pops_inst[0]); end
    n_checks++; if (pops_pc[1] !== exp1) begin n_fail++; $display("FAIL jal_next: got %h expected %h", pops_pc[1], exp1); end
    n_checks++; if (pops_pc[2] !== exp1 + 32'd4) begin n_fail++; $display("FAIL jal_after: got %h expected %h", pops_pc[2], exp1 + 32'd4); end
  endtask

  task automatic test_reset_midburst();
    if_out_ready = 1'b1;
    do_reset();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (axi_arvalid !== 1'b0 || axi_rready !== 1'b0 || if_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b%b%b expected 000", axi_arvalid, axi_rready, if_out_valid); end
    n_checks++; if ({if_out_inst, if_out_pc, if_out_fault} !== 65'h0 || axi_araddr !== 32'h3000_0000) begin n_fail++; $display("FAIL midrst_data: got %h/%h/%b addr %h expected 0 addr 30000000", if_out_inst, if_out_pc, if_out_fault, axi_araddr); end
    reset = 1'b0;
    collect(3, 30);
    n_checks++; if (pops_pc[0] !== 32'h3000_0000 || pops_pc[2] !== 32'h3000_0008) begin n_fail++; $display("FAIL midrst_restart: got %h %h expected 30000000 30000008", pops_pc[0], pops_pc[2]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_flush();
    test_priority();
    test_fault();
    test_jal();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
